// File: rtl/stream_rx_pkg.sv
// Shared types and default widths for the stream sequence receiver.
package stream_rx_pkg;

  localparam int unsigned DATA_W_DEF      = 8;
  localparam int unsigned DEPTH_DEF       = 4;
  localparam int unsigned CNT_W_DEF       = 16;
  localparam int unsigned LOSS_THRESH_DEF = 3;

  typedef enum logic {
    HUNT   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  typedef struct packed {
    logic                  seq_err;
    logic [DATA_W_DEF-1:0] data;
  } fifo_entry_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy counter; head is a mux of registered storage.
module sync_fifo #(
  parameter int unsigned WIDTH = 9,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic             full_c,
  output logic             empty_c,
  output logic [WIDTH-1:0] head_c
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic             do_push;
  logic             do_pop;

  assign full_c  = (count == CW'(DEPTH));
  assign empty_c = (count == '0);
  assign head_c  = mem[rd_ptr];
  assign do_pop  = pop & ~empty_c;
  assign do_push = push & (~full_c | do_pop);

  // Storage, pointers (natural wrap, DEPTH is a power of two) and occupancy.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < int'(DEPTH); i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (do_pop) rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/stream_seq_receiver.sv
// Receive endpoint: checks +1 sequence, tracks lock, counts errors, buffers bytes.
module stream_seq_receiver
  import stream_rx_pkg::*;
#(
  parameter int unsigned DATA_W      = DATA_W_DEF,
  parameter int unsigned DEPTH       = DEPTH_DEF,
  parameter int unsigned CNT_W       = CNT_W_DEF,
  parameter int unsigned LOSS_THRESH = LOSS_THRESH_DEF
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_seq_err,
  output logic              locked,
  output logic [CNT_W-1:0]  err_count,
  output logic              overflow,
  input  logic              clear
);

  localparam int unsigned CONW = $clog2(LOSS_THRESH + 1);
  localparam int unsigned EW   = DATA_W + 1;

  state_t            state;
  state_t            state_next;
  logic [DATA_W-1:0] expected;
  logic [DATA_W-1:0] expected_next;
  logic [CONW-1:0]   consec;
  logic [CONW-1:0]   consec_next;
  logic              tag;
  logic              full;
  logic              empty;
  logic              pop_fire;
  logic              drop;
  logic [EW-1:0]     head;

  assign out_valid   = ~empty;
  assign pop_fire    = out_valid & out_ready;
  assign drop        = in_valid & full & ~pop_fire;
  assign out_seq_err = head[EW-1];
  assign out_data    = head[DATA_W-1:0];
  assign locked      = (state == LOCKED);

  sync_fifo #(
    .WIDTH (EW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (in_valid),
    .push_data ({tag, in_data}),
    .pop       (pop_fire),
    .full_c    (full),
    .empty_c   (empty),
    .head_c    (head)
  );

  // Checker state registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= HUNT;
      expected <= '0;
      consec   <= '0;
    end else begin
      state    <= state_next;
      expected <= expected_next;
      consec   <= consec_next;
    end
  end

  // Next-state, resync and mismatch tag for the byte on the input.
  always_comb begin
    state_next    = state;
    expected_next = expected;
    consec_next   = consec;
    tag           = 1'b0;
    if (in_valid) begin
      expected_next = in_data + DATA_W'(1);
      case (state)
        HUNT: begin
          consec_next = '0;
          state_next  = LOCKED;
        end
        LOCKED: begin
          if (in_data == expected) begin
            consec_next = '0;
          end else begin
            tag = 1'b1;
            if (consec == CONW'(LOSS_THRESH - 1)) begin
              state_next  = HUNT;
              consec_next = '0;
            end else begin
              consec_next = consec + CONW'(1);
            end
          end
        end
        default: state_next = HUNT;
      endcase
    end
  end

  // Saturating error counter and sticky overflow; clear takes priority.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      err_count <= '0;
      overflow  <= 1'b0;
    end else if (clear) begin
      err_count <= '0;
      overflow  <= 1'b0;
    end else begin
      if (tag && (err_count != '1)) err_count <= err_count + CNT_W'(1);
      if (drop) overflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_stream_seq_receiver.sv
// Self-checking bench: directed literal checks plus randomized traffic vs a queue model.
module tb_stream_seq_receiver;
  import stream_rx_pkg::*;

  localparam int DEPTH = 4;
  localparam int LOSS  = 3;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = 8'h00;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [7:0]  out_data;
  logic        out_seq_err;
  logic        locked;
  logic [15:0] err_count;
  logic        overflow;
  logic        clear = 1'b0;

  int total = 0;
  int bad   = 0;

  stream_seq_receiver dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .in_valid    (in_valid),
    .in_data     (in_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .out_seq_err (out_seq_err),
    .locked      (locked),
    .err_count   (err_count),
    .overflow    (overflow),
    .clear       (clear)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: queue of entries, lock flag, expected value, counters.
  fifo_entry_t q[$];
  bit          m_locked;
  int          m_exp;
  int          m_consec;
  int          m_err;
  bit          m_ovf;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      q.delete();
      m_locked = 0;
      m_exp    = 0;
      m_consec = 0;
      m_err    = 0;
      m_ovf    = 0;
    end else begin
      bit pop;
      bit was_full;
      fifo_entry_t e;
      pop      = (q.size() > 0) && out_ready;
      was_full = (q.size() == DEPTH);
      e.seq_err = 1'b0;
      e.data    = in_data;
      if (in_valid) begin
        if (!m_locked) begin
          m_locked = 1;
          m_consec = 0;
        end else if (int'(in_data) == m_exp) begin
          m_consec = 0;
        end else begin
          e.seq_err = 1'b1;
          if (m_err < 65535) m_err++;
          m_consec++;
          if (m_consec == LOSS) begin
            m_locked = 0;
            m_consec = 0;
          end
        end
        m_exp = (int'(in_data) + 1) % 256;
      end
      if (pop) void'(q.pop_front());
      if (in_valid) begin
        if (!was_full || pop) q.push_back(e);
        else m_ovf = 1;
      end
      if (clear) begin
        m_err = 0;
        m_ovf = 0;
      end
    end
  end

  // Every-cycle comparison of DUT outputs against the model.
  always @(negedge clk) begin
    if (reset_n) begin
      check("out_valid", 32'(out_valid), 32'(q.size() > 0));
      if (q.size() > 0) begin
        check("out_data", 32'(out_data), 32'(q[0].data));
        check("out_seq_err", 32'(out_seq_err), 32'(q[0].seq_err));
      end
      check("locked", 32'(locked), 32'(m_locked));
      check("err_count", 32'(err_count), 32'(m_err));
      check("overflow", 32'(overflow), 32'(m_ovf));
    end
  end

  task automatic step(input logic v, input logic [7:0] d, input logic r);
    in_valid  = v;
    in_data   = d;
    out_ready = r;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    in_valid = 1'b0;
    clear    = 1'b0;
    reset_n  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  initial begin
    logic [7:0] nxt;
    do_reset();
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", 32'(out_data), 32'd0);
    check("rst_locked", 32'(locked), 32'd0);
    check("rst_err", 32'(err_count), 32'd0);
    check("rst_ovf", 32'(overflow), 32'd0);

    // Basic in-order stream with one-cycle latency.
    step(1, 8'h10, 1);
    check("t1_d10", 32'(out_data), 32'h10);
    check("t1_lock", 32'(locked), 32'd1);
    step(1, 8'h11, 1);
    check("t1_d11", 32'(out_data), 32'h11);
    step(1, 8'h12, 1);
    check("t1_d12", 32'(out_data), 32'h12);
    check("t1_err", 32'(err_count), 32'd0);
    check("t1_tag", 32'(out_seq_err), 32'd0);

    // Wrap through 0xFF -> 0x00.
    do_reset();
    step(1, 8'hFE, 1);
    step(1, 8'hFF, 1);
    step(1, 8'h00, 1);
    step(1, 8'h01, 1);
    check("t2_err", 32'(err_count), 32'd0);
    check("t2_d01", 32'(out_data), 32'h01);

    // Single mismatch with resync.
    do_reset();
    step(1, 8'h20, 1);
    step(1, 8'h21, 1);
    step(1, 8'h25, 1);
    check("t3_tag25", 32'(out_seq_err), 32'd1);
    check("t3_err", 32'(err_count), 32'd1);
    step(1, 8'h26, 1);
    check("t3_tag26", 32'(out_seq_err), 32'd0);
    check("t3_lock", 32'(locked), 32'd1);

    // Loss of lock after three consecutive mismatches.
    do_reset();
    step(1, 8'h30, 1);
    step(1, 8'h40, 1);
    step(1, 8'h50, 1);
    check("t4_lock_mid", 32'(locked), 32'd1);
    step(1, 8'h60, 1);
    check("t4_err", 32'(err_count), 32'd3);
    check("t4_unlock", 32'(locked), 32'd0);
    step(1, 8'h61, 1);
    check("t4_relock", 32'(locked), 32'd1);
    check("t4_err2", 32'(err_count), 32'd3);
    check("t4_tag61", 32'(out_seq_err), 32'd0);

    // Overflow with back-pressure, drain, then clear.
    do_reset();
    for (int i = 0; i < 6; i++) step(1, 8'(i), 0);
    check("t5_ovf", 32'(overflow), 32'd1);
    for (int i = 0; i < 4; i++) begin
      check("t5_drain_valid", 32'(out_valid), 32'd1);
      check("t5_drain_data", 32'(out_data), 32'(i));
      step(0, 8'h00, 1);
    end
    check("t5_empty", 32'(out_valid), 32'd0);
    clear = 1'b1;
    step(0, 8'h00, 0);
    clear = 1'b0;
    check("t5_clr", 32'(overflow), 32'd0);

    // Push and pop at full, then asynchronous reset mid-stream.
    do_reset();
    for (int i = 0; i < 4; i++) step(1, 8'(8'h40 + i), 0);
    step(1, 8'h44, 1);
    check("t6_ovf", 32'(overflow), 32'd0);
    check("t6_head", 32'(out_data), 32'h41);
    step(1, 8'h45, 0);
    check("t6_was_full", 32'(overflow), 32'd1);
    in_valid = 1'b1;
    in_data  = 8'h46;
    #2;
    reset_n = 1'b0;
    #1;
    check("t6_arst_valid", 32'(out_valid), 32'd0);
    check("t6_arst_lock", 32'(locked), 32'd0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;

    // Randomized traffic checked by the every-cycle comparator.
    nxt = 8'($urandom);
    for (int c = 0; c < 3000; c++) begin
      logic       v;
      logic [7:0] d;
      v = ($urandom_range(0, 99) < 75);
      d = ($urandom_range(0, 99) < 88) ? nxt : 8'($urandom);
      if (v) nxt = d + 8'd1;
      clear = ($urandom_range(0, 59) == 0);
      if ($urandom_range(0, 599) == 0) begin
        reset_n = 1'b0;
        #2;
        reset_n = 1'b1;
      end
      step(v, d, ($urandom_range(0, 99) < 55));
    end
    clear    = 1'b0;
    in_valid = 1'b0;
    @(posedge clk);
    #1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
